// File: rtl/multibank_pingpong_buffer.sv
// rtl/multibank_pingpong_buffer.sv - N-bank round-robin ping-pong tile buffer with replayable drain
module multibank_pingpong_buffer #(
    parameter int NUM_BANKS = 2,
    parameter int DEPTH     = 8,
    parameter int NUM_CH    = 2,
    parameter int DATA_W    = 16,
    parameter int REPLAY_W  = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [NUM_CH*DATA_W-1:0]         in_data,
    input  logic                             in_last,
    input  logic [REPLAY_W-1:0]              cfg_replay,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_CH*DATA_W-1:0]         out_data,
    output logic                             out_last,
    output logic                             out_bank_done,
    output logic [$clog2(NUM_BANKS)-1:0]     out_bank_idx,
    output logic [$clog2(NUM_BANKS)-1:0]     wr_bank_idx,
    output logic [$clog2(NUM_BANKS+1)-1:0]   full_cnt
);
    localparam int BW = $clog2(NUM_BANKS);
    localparam int CW = $clog2(NUM_BANKS + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int WW = NUM_CH * DATA_W;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    bank_state_t           bank_st     [NUM_BANKS];
    bank_state_t           bank_st_nxt [NUM_BANKS];
    logic [WW-1:0]         mem         [NUM_BANKS][DEPTH];
    logic [LW-1:0]         len         [NUM_BANKS];

    logic [BW-1:0]         wr_bank;
    logic [AW-1:0]         wr_addr;
    logic [BW-1:0]         rd_bank;
    logic [AW-1:0]         rd_addr;
    logic                  rd_busy;
    logic [REPLAY_W-1:0]   passes_left;

    logic                  wr_fire;
    logic                  wr_close;
    logic                  rd_start;
    logic [REPLAY_W-1:0]   cfg_passes;
    logic [REPLAY_W-1:0]   cur_passes;
    logic                  rd_is_last;
    logic                  rd_is_done;
    logic                  out_load;
    logic                  rd_free;

    function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
        return (b == BW'(NUM_BANKS - 1)) ? '0 : b + BW'(1);
    endfunction

    assign in_ready    = (bank_st[wr_bank] == BANK_EMPTY);
    assign wr_bank_idx = wr_bank;

    assign wr_fire    = in_valid && in_ready;
    assign wr_close   = wr_fire && ((wr_addr == AW'(DEPTH - 1)) || in_last);
    assign rd_start   = !rd_busy && (bank_st[rd_bank] == BANK_FULL);
    // A replay count of zero still drains the bank once
    assign cfg_passes = (cfg_replay == '0) ? REPLAY_W'(1) : cfg_replay;
    // On the starting edge passes_left is not loaded yet, so use the sampled config
    assign cur_passes = rd_busy ? passes_left : cfg_passes;
    assign rd_is_last = (LW'(rd_addr) == (len[rd_bank] - LW'(1)));
    assign rd_is_done = rd_is_last && (cur_passes == REPLAY_W'(1));
    assign out_load   = (rd_busy || rd_start) && (!out_valid || out_ready);
    assign rd_free    = out_load && rd_is_done;

    // Bank state next-state: writer closes its bank, reader claims and frees its bank
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_st_nxt[b] = bank_st[b];
        end
        if (wr_close) begin
            bank_st_nxt[wr_bank] = BANK_FULL;
        end
        if (rd_free) begin
            bank_st_nxt[rd_bank] = BANK_EMPTY;
        end else if (rd_start) begin
            bank_st_nxt[rd_bank] = BANK_DRAINING;
        end
    end

    // Bank state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_st[b] <= BANK_EMPTY;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_st[b] <= bank_st_nxt[b];
            end
        end
    end

    // Tile storage and per-bank length; length is only read once the bank is closed
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank][wr_addr] <= in_data;
        end
        if (wr_close) begin
            len[wr_bank] <= LW'(wr_addr) + LW'(1);
        end
    end

    // Write pointer: advance address, roll to the next bank on close
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank <= '0;
            wr_addr <= '0;
        end else if (wr_fire) begin
            if (wr_close) begin
                wr_addr <= '0;
                wr_bank <= next_bank(wr_bank);
            end else begin
                wr_addr <= wr_addr + AW'(1);
            end
        end
    end

    // Read pointer and replay counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_busy     <= 1'b0;
            rd_bank     <= '0;
            rd_addr     <= '0;
            passes_left <= '0;
        end else if (out_load) begin
            if (rd_is_last) begin
                rd_addr     <= '0;
                passes_left <= cur_passes - REPLAY_W'(1);
            end else begin
                rd_addr     <= rd_addr + AW'(1);
                passes_left <= cur_passes;
            end
            if (rd_is_done) begin
                rd_busy <= 1'b0;
                rd_bank <= next_bank(rd_bank);
            end else begin
                rd_busy <= 1'b1;
            end
        end else if (rd_start) begin
            rd_busy     <= 1'b1;
            passes_left <= cfg_passes;
        end
    end

    // Output register: reload whenever empty or being consumed, hold under stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            out_bank_done <= 1'b0;
            out_bank_idx  <= '0;
        end else if (out_load) begin
            out_valid     <= 1'b1;
            out_data      <= mem[rd_bank][rd_addr];
            out_last      <= rd_is_last;
            out_bank_done <= rd_is_done;
            out_bank_idx  <= rd_bank;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Occupied-bank counter; a close and a free on the same edge cancel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_cnt <= '0;
        end else begin
            full_cnt <= full_cnt + CW'(wr_close) - CW'(rd_free);
        end
    end
endmodule

// File: tb/tb_multibank_pingpong_buffer.sv
// tb/tb_multibank_pingpong_buffer.sv - directed self-checking bench for multibank_pingpong_buffer
module tb_multibank_pingpong_buffer;
    logic        clk = 1'b0;
    logic        rst_n;

    logic        a_in_valid, a_in_ready, a_in_last;
    logic [31:0] a_in_data;
    logic [3:0]  a_cfg;
    logic        a_out_valid, a_out_ready, a_out_last, a_out_done;
    logic [31:0] a_out_data;
    logic [0:0]  a_out_idx, a_wr_idx;
    logic [1:0]  a_full_cnt;

    logic        b_in_valid, b_in_ready, b_in_last;
    logic [31:0] b_in_data;
    logic [3:0]  b_cfg;
    logic        b_out_valid, b_out_ready, b_out_last, b_out_done;
    logic [31:0] b_out_data;
    logic [1:0]  b_out_idx, b_wr_idx;
    logic [1:0]  b_full_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multibank_pingpong_buffer #(.NUM_BANKS(2), .DEPTH(4), .NUM_CH(2), .DATA_W(16), .REPLAY_W(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
        .cfg_replay(a_cfg),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .out_bank_done(a_out_done), .out_bank_idx(a_out_idx),
        .wr_bank_idx(a_wr_idx), .full_cnt(a_full_cnt)
    );

    multibank_pingpong_buffer #(.NUM_BANKS(3), .DEPTH(4), .NUM_CH(2), .DATA_W(16), .REPLAY_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
        .cfg_replay(b_cfg),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .out_bank_done(b_out_done), .out_bank_idx(b_out_idx),
        .wr_bank_idx(b_wr_idx), .full_cnt(b_full_cnt)
    );

    function automatic logic [31:0] word(input int v);
        return {16'(v + 256), 16'(v)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_a(input int v, input bit last);
        int n = 0;
        a_in_valid = 1'b1;
        a_in_data  = word(v);
        a_in_last  = last;
        while (!a_in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("put_ready", 64'(a_in_ready), 64'd1);
        tick();
        a_in_valid = 1'b0;
        a_in_last  = 1'b0;
    endtask

    task automatic get_a(input int v, input bit last, input bit done, input int idx, input bit strict);
        int n = 0;
        if (!strict) begin
            while (!a_out_valid && n < 50) begin
                tick();
                n++;
            end
        end
        chk("get_valid", 64'(a_out_valid), 64'd1);
        chk("get_data", 64'(a_out_data), 64'(word(v)));
        chk("get_last", 64'(a_out_last), 64'(last));
        chk("get_done", 64'(a_out_done), 64'(done));
        chk("get_idx", 64'(a_out_idx), 64'(idx));
        tick();
    endtask

    initial begin
        int pat[4] = '{1, 0, 0, 1};
        int idx;

        rst_n = 1'b0;
        a_in_valid = 0; a_in_data = '0; a_in_last = 0; a_cfg = 4'd1; a_out_ready = 0;
        b_in_valid = 0; b_in_data = '0; b_in_last = 0; b_cfg = 4'd1; b_out_ready = 0;

        // reset state
        tick();
        tick();
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_full_cnt", 64'(a_full_cnt), 64'd0);
        chk("rst_wr_idx", 64'(a_wr_idx), 64'd0);
        chk("rst_out_data", 64'(a_out_data), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);

        // single fill, single pass, one-cycle latency after closing write
        a_out_ready = 1;
        for (int i = 1; i <= 4; i++) put_a(i, 0);
        chk("t1_valid_lat0", 64'(a_out_valid), 64'd0);
        chk("t1_full_cnt", 64'(a_full_cnt), 64'd1);
        chk("t1_wr_idx", 64'(a_wr_idx), 64'd1);
        tick();
        for (int i = 1; i <= 4; i++) get_a(i, i == 4, i == 4, 0, 1);
        chk("t1_idle", 64'(a_out_valid), 64'd0);
        chk("t1_full_cnt0", 64'(a_full_cnt), 64'd0);

        // replay x3 on bank 1, bank 0 filled behind it
        a_cfg = 4'd3;
        a_out_ready = 0;
        for (int i = 5; i <= 12; i++) put_a(i, 0);
        chk("t2_in_ready", 64'(a_in_ready), 64'd0);
        chk("t2_full_cnt", 64'(a_full_cnt), 64'd2);
        tick();
        tick();
        chk("t2_stall_data", 64'(a_out_data), 64'(word(5)));
        chk("t2_stall_idx", 64'(a_out_idx), 64'd1);
        a_cfg = 4'd1;
        a_out_ready = 1;
        for (int p = 0; p < 3; p++) begin
            for (int i = 5; i <= 8; i++) get_a(i, i == 8, (i == 8) && (p == 2), 1, 1);
            if (p == 0) chk("t2_in_ready_drain", 64'(a_in_ready), 64'd0);
        end
        for (int i = 9; i <= 12; i++) get_a(i, i == 12, i == 12, 0, 1);
        chk("t2_idle", 64'(a_out_valid), 64'd0);

        // partial bank and len=1 bank, replay 0 acts as 1
        a_cfg = 4'd0;
        put_a(16'h0A, 0);
        put_a(16'h0B, 1);
        chk("t3_wr_idx", 64'(a_wr_idx), 64'd0);
        chk("t3_full_cnt", 64'(a_full_cnt), 64'd1);
        tick();
        get_a(16'h0A, 0, 0, 1, 1);
        get_a(16'h0B, 1, 1, 1, 1);
        chk("t3_idle", 64'(a_out_valid), 64'd0);
        put_a(16'h0C, 1);
        tick();
        get_a(16'h0C, 1, 1, 0, 1);

        // backpressure 1,0,0,1
        a_cfg = 4'd1;
        a_out_ready = 0;
        for (int i = 21; i <= 24; i++) put_a(i, 0);
        idx = 0;
        for (int c = 0; c < 40 && idx < 4; c++) begin
            a_out_ready = pat[c % 4][0];
            if (a_out_valid) begin
                chk("t4_data", 64'(a_out_data), 64'(word(21 + idx)));
                chk("t4_last", 64'(a_out_last), 64'(idx == 3));
                if (a_out_ready) idx++;
            end
            tick();
        end
        chk("t4_count", 64'(idx), 64'd4);
        a_out_ready = 1;
        chk("t4_idle", 64'(a_out_valid), 64'd0);

        // all banks occupied
        a_out_ready = 0;
        for (int i = 31; i <= 38; i++) put_a(i, 0);
        chk("t5_in_ready", 64'(a_in_ready), 64'd0);
        chk("t5_full_cnt", 64'(a_full_cnt), 64'd2);
        a_in_valid = 1; a_in_data = word(99);
        tick(); tick(); tick();
        a_in_valid = 0;
        chk("t5_full_hold", 64'(a_full_cnt), 64'd2);
        chk("t5_wr_idx_hold", 64'(a_wr_idx), 64'd0);
        a_out_ready = 1;
        for (int i = 31; i <= 33; i++) get_a(i, 0, 0, 0, 1);
        chk("t5_reopen", 64'(a_in_ready), 64'd1);
        chk("t5_full_cnt1", 64'(a_full_cnt), 64'd1);
        get_a(34, 1, 1, 0, 1);
        for (int i = 35; i <= 38; i++) get_a(i, i == 38, i == 38, 1, 1);
        chk("t5_idle", 64'(a_out_valid), 64'd0);

        // reset during second pass
        a_cfg = 4'd2;
        for (int i = 41; i <= 44; i++) put_a(i, 0);
        tick();
        for (int i = 41; i <= 44; i++) get_a(i, i == 44, 0, 0, 1);
        get_a(41, 0, 0, 0, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 64'(a_out_valid), 64'd0);
        chk("t6_full_cnt", 64'(a_full_cnt), 64'd0);
        chk("t6_in_ready", 64'(a_in_ready), 64'd1);
        chk("t6_out_data", 64'(a_out_data), 64'd0);
        tick();
        rst_n = 1'b1;
        a_cfg = 4'd1;
        for (int i = 51; i <= 54; i++) put_a(i, 0);
        tick();
        for (int i = 51; i <= 54; i++) get_a(i, i == 54, i == 54, 0, 1);

        // three-bank streaming with no bubbles
        for (int i = 0; i < 12; i++) begin
            b_in_valid = 1; b_in_data = word(i + 1); b_in_last = 0;
            tick();
        end
        b_in_valid = 0;
        chk("b_full_cnt", 64'(b_full_cnt), 64'd3);
        chk("b_in_ready", 64'(b_in_ready), 64'd0);
        b_out_ready = 1;
        for (int i = 0; i < 12; i++) begin
            chk("b_valid", 64'(b_out_valid), 64'd1);
            chk("b_data", 64'(b_out_data), 64'(word(i + 1)));
            chk("b_idx", 64'(b_out_idx), 64'(i / 4));
            chk("b_done", 64'(b_out_done), 64'((i % 4) == 3));
            tick();
        end
        chk("b_idle", 64'(b_out_valid), 64'd0);
        chk("b_full_cnt0", 64'(b_full_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
